// File: rtl/lcd_panel_receiver.sv
// Panel-side responder for a 16-bit 8080-style write bus: samples the bus, decodes
// command/parameter writes, tracks the column/page window and emits addressed pixels.
module lcd_panel_receiver #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter logic [9:0]  COL_DEF_END  = 10'd853,
    parameter logic [9:0]  PAGE_DEF_END = 10'd479
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] lcd_data,
    input  logic        cs,
    input  logic        rs,
    input  logic        wr,
    input  logic        rd,
    input  logic        rst,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic        param_valid,
    output logic [3:0]  param_idx,
    output logic [7:0]  param_data,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        frame_done,
    output logic        sleep_out,
    output logic        disp_on,
    output logic        err
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned BUS_W  = DATA_W + 5;
    localparam int unsigned CS_B   = DATA_W + 4;
    localparam int unsigned RS_B   = DATA_W + 3;
    localparam int unsigned WR_B   = DATA_W + 2;
    localparam int unsigned RD_B   = DATA_W + 1;
    localparam int unsigned RST_B  = DATA_W;
    // Reset value of the sampler matches an idle bus so no false edge appears.
    localparam logic [BUS_W-1:0] BUS_IDLE = {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PARAM = 2'd1,
        S_MEMWR = 2'd2
    } state_t;

    logic [BUS_W-1:0]  sync_q [SYNC_STAGES];
    logic              b_wr_q;
    logic              b_rs_q;
    logic [DATA_W-1:0] b_data_q;

    logic a_cs, a_wr, a_rd, a_rst;
    logic strobe, cmd_strb, data_strb;

    state_t      state_q, state_d;
    logic [9:0]  col_start_q, col_start_d, col_end_q, col_end_d;
    logic [9:0]  page_start_q, page_start_d, page_end_q, page_end_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [3:0]  pcnt_q, pcnt_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [7:0]  cmd_code_q, cmd_code_d;
    logic        param_valid_q, param_valid_d;
    logic [3:0]  param_idx_q, param_idx_d;
    logic [7:0]  param_data_q, param_data_d;
    logic        pix_valid_q, pix_valid_d;
    logic [15:0] pix_data_q, pix_data_d;
    logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic        frame_done_q, frame_done_d;
    logic        sleep_q, sleep_d, disp_q, disp_d;
    logic        err_q, err_d;

    // Input sampler: SYNC_STAGES-deep pipeline (last stage = A) plus the B copy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= BUS_IDLE;
            end
            b_wr_q   <= 1'b1;
            b_rs_q   <= 1'b0;
            b_data_q <= '0;
        end else begin
            sync_q[0] <= {cs, rs, wr, rd, rst, lcd_data};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            b_wr_q   <= sync_q[SYNC_STAGES-1][WR_B];
            b_rs_q   <= sync_q[SYNC_STAGES-1][RS_B];
            b_data_q <= sync_q[SYNC_STAGES-1][DATA_W-1:0];
        end
    end

    assign a_cs      = sync_q[SYNC_STAGES-1][CS_B];
    assign a_wr      = sync_q[SYNC_STAGES-1][WR_B];
    assign a_rd      = sync_q[SYNC_STAGES-1][RD_B];
    assign a_rst     = sync_q[SYNC_STAGES-1][RST_B];
    assign strobe    = a_wr & ~b_wr_q & ~a_cs & a_rd & a_rst;
    assign cmd_strb  = strobe & ~b_rs_q;
    assign data_strb = strobe & b_rs_q;

    // Next-state and output decode.
    always_comb begin
        state_d       = state_q;
        col_start_d   = col_start_q;
        col_end_d     = col_end_q;
        page_start_d  = page_start_q;
        page_end_d    = page_end_q;
        x_d           = x_q;
        y_d           = y_q;
        pcnt_d        = pcnt_q;
        cmd_valid_d   = 1'b0;
        cmd_code_d    = cmd_code_q;
        param_valid_d = 1'b0;
        param_idx_d   = param_idx_q;
        param_data_d  = param_data_q;
        pix_valid_d   = 1'b0;
        pix_data_d    = pix_data_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        frame_done_d  = 1'b0;
        sleep_d       = sleep_q;
        disp_d        = disp_q;
        err_d         = 1'b0;

        if (!a_rst) begin
            state_d      = S_IDLE;
            col_start_d  = 10'd0;
            col_end_d    = COL_DEF_END;
            page_start_d = 10'd0;
            page_end_d   = PAGE_DEF_END;
            pcnt_d       = 4'd0;
            sleep_d      = 1'b0;
            disp_d       = 1'b0;
        end else if (cmd_strb) begin
            cmd_valid_d = 1'b1;
            cmd_code_d  = b_data_q[7:0];
            pcnt_d      = 4'd0;
            case (b_data_q[7:0])
                8'h2A, 8'h2B: state_d = S_PARAM;
                8'h2C: begin
                    if ((col_start_q > col_end_q) || (page_start_q > page_end_q)) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        x_d     = col_start_q;
                        y_d     = page_start_q;
                        state_d = S_MEMWR;
                    end
                end
                8'h11: begin sleep_d = 1'b1; state_d = S_IDLE; end
                8'h10: begin sleep_d = 1'b0; state_d = S_IDLE; end
                8'h29: begin disp_d  = 1'b1; state_d = S_IDLE; end
                8'h28: begin disp_d  = 1'b0; state_d = S_IDLE; end
                default: state_d = S_PARAM;
            endcase
        end else if (data_strb) begin
            case (state_q)
                S_PARAM: begin
                    param_valid_d = 1'b1;
                    param_idx_d   = pcnt_q;
                    param_data_d  = b_data_q[7:0];
                    if (pcnt_q != 4'hF) begin
                        pcnt_d = pcnt_q + 4'd1;
                    end
                    // High bytes keep only bits [1:0]; window is 10 bits wide.
                    if (cmd_code_q == 8'h2A) begin
                        case (pcnt_q)
                            4'd0: col_start_d = {b_data_q[1:0], col_start_q[7:0]};
                            4'd1: col_start_d = {col_start_q[9:8], b_data_q[7:0]};
                            4'd2: col_end_d   = {b_data_q[1:0], col_end_q[7:0]};
                            4'd3: col_end_d   = {col_end_q[9:8], b_data_q[7:0]};
                            default: ;
                        endcase
                    end else if (cmd_code_q == 8'h2B) begin
                        case (pcnt_q)
                            4'd0: page_start_d = {b_data_q[1:0], page_start_q[7:0]};
                            4'd1: page_start_d = {page_start_q[9:8], b_data_q[7:0]};
                            4'd2: page_end_d   = {b_data_q[1:0], page_end_q[7:0]};
                            4'd3: page_end_d   = {page_end_q[9:8], b_data_q[7:0]};
                            default: ;
                        endcase
                    end
                end
                S_MEMWR: begin
                    pix_valid_d = 1'b1;
                    pix_data_d  = b_data_q;
                    pix_x_d     = x_q;
                    pix_y_d     = y_q;
                    if (x_q == col_end_q) begin
                        x_d = col_start_q;
                        if (y_q == page_end_q) begin
                            y_d          = page_start_q;
                            frame_done_d = 1'b1;
                        end else begin
                            y_d = y_q + 10'd1;
                        end
                    end else begin
                        x_d = x_q + 10'd1;
                    end
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            col_start_q   <= 10'd0;
            col_end_q     <= COL_DEF_END;
            page_start_q  <= 10'd0;
            page_end_q    <= PAGE_DEF_END;
            x_q           <= 10'd0;
            y_q           <= 10'd0;
            pcnt_q        <= 4'd0;
            cmd_valid_q   <= 1'b0;
            cmd_code_q    <= 8'h00;
            param_valid_q <= 1'b0;
            param_idx_q   <= 4'd0;
            param_data_q  <= 8'h00;
            pix_valid_q   <= 1'b0;
            pix_data_q    <= 16'h0000;
            pix_x_q       <= 10'd0;
            pix_y_q       <= 10'd0;
            frame_done_q  <= 1'b0;
            sleep_q       <= 1'b0;
            disp_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_start_q   <= col_start_d;
            col_end_q     <= col_end_d;
            page_start_q  <= page_start_d;
            page_end_q    <= page_end_d;
            x_q           <= x_d;
            y_q           <= y_d;
            pcnt_q        <= pcnt_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_code_q    <= cmd_code_d;
            param_valid_q <= param_valid_d;
            param_idx_q   <= param_idx_d;
            param_data_q  <= param_data_d;
            pix_valid_q   <= pix_valid_d;
            pix_data_q    <= pix_data_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            frame_done_q  <= frame_done_d;
            sleep_q       <= sleep_d;
            disp_q        <= disp_d;
            err_q         <= err_d;
        end
    end

    assign cmd_valid   = cmd_valid_q;
    assign cmd_code    = cmd_code_q;
    assign param_valid = param_valid_q;
    assign param_idx   = param_idx_q;
    assign param_data  = param_data_q;
    assign pix_valid   = pix_valid_q;
    assign pix_data    = pix_data_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign frame_done  = frame_done_q;
    assign sleep_out   = sleep_q;
    assign disp_on     = disp_q;
    assign err         = err_q;

endmodule

// File: tb/tb_lcd_panel_receiver.sv
// Directed bench for lcd_panel_receiver: drives 8080-style writes and checks
// decoded commands, parameters, pixel coordinates, status and error pulses.
module tb_lcd_panel_receiver;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] lcd_data;
    logic        cs, rs, wr, rd, rst;
    logic        cmd_valid, param_valid, pix_valid, frame_done, sleep_out, disp_on, err;
    logic [7:0]  cmd_code, param_data;
    logic [3:0]  param_idx;
    logic [15:0] pix_data;
    logic [9:0]  pix_x, pix_y;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned cyc = 0;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] d;
        logic        fd;
        int unsigned c;
    } pix_ev_t;

    pix_ev_t     pix_q[$];
    int unsigned rise_q[$];
    logic [3:0]  par_i_q[$];
    logic [7:0]  par_d_q[$];
    int unsigned err_cnt, cmd_cnt, frame_cnt;

    lcd_panel_receiver dut (
        .clk(clk), .reset(reset), .lcd_data(lcd_data), .cs(cs), .rs(rs), .wr(wr),
        .rd(rd), .rst(rst), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .param_valid(param_valid), .param_idx(param_idx), .param_data(param_data),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
        .frame_done(frame_done), .sleep_out(sleep_out), .disp_on(disp_on), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder: every pulse seen on a falling edge is logged once per cycle.
    always @(negedge clk) begin
        if (pix_valid === 1'b1) pix_q.push_back('{pix_x, pix_y, pix_data, frame_done, cyc});
        if (param_valid === 1'b1) begin
            par_i_q.push_back(param_idx);
            par_d_q.push_back(param_data);
        end
        if (err === 1'b1) err_cnt++;
        if (cmd_valid === 1'b1) cmd_cnt++;
        if (frame_done === 1'b1) frame_cnt++;
    end

    task automatic clear_events();
        pix_q.delete();
        rise_q.delete();
        par_i_q.delete();
        par_d_q.delete();
        err_cnt = 0;
        cmd_cnt = 0;
        frame_cnt = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic rs_v, input logic [15:0] d_v,
                             input logic cs_v, input logic rd_v);
        @(negedge clk);
        cs = cs_v; rd = rd_v; rs = rs_v; lcd_data = d_v; wr = 1'b0;
        repeat (2) @(negedge clk);
        wr = 1'b1;
        rise_q.push_back(cyc);
        repeat (2) @(negedge clk);
    endtask

    task automatic cmd(input logic [7:0] c);
        bus_write(1'b0, {8'h00, c}, 1'b0, 1'b1);
    endtask

    task automatic dat(input logic [15:0] d);
        bus_write(1'b1, d, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        logic [76:0] outs;
        reset = 1'b0; rst = 1'b1; cs = 1'b1; rs = 1'b0; wr = 1'b1; rd = 1'b1;
        lcd_data = 16'h0000;
        idle(3);
        outs = {cmd_valid, cmd_code, param_valid, param_idx, param_data, pix_valid,
                pix_data, pix_x, pix_y, frame_done, sleep_out, disp_on, err};
        vectors++;
        if (outs !== 77'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        reset = 1'b1;
        idle(4);
        clear_events();
        outs = {cmd_valid, cmd_code, param_valid, param_idx, param_data, pix_valid,
                pix_data, pix_x, pix_y, frame_done, sleep_out, disp_on, err};
        vectors++;
        if (outs !== 77'd0) begin
            miscompares++;
            $display("FAIL reset_release_outputs: got %h want 0", outs);
        end
    endtask

    task automatic test_memwr_basic();
        logic [15:0] exp_d [3] = '{16'h1111, 16'h2222, 16'h3333};
        clear_events();
        cmd(8'h2C);
        for (int i = 0; i < 3; i++) dat(exp_d[i]);
        idle(4);
        vectors++;
        if (pix_q.size() !== 3) begin
            miscompares++;
            $display("FAIL basic_pix_count: got %0d want 3", pix_q.size());
        end
        for (int i = 0; i < 3 && i < pix_q.size(); i++) begin
            vectors++;
            if (pix_q[i].x !== 10'(i) || pix_q[i].y !== 10'd0 || pix_q[i].d !== exp_d[i]
                || pix_q[i].fd !== 1'b0) begin
                miscompares++;
                $display("FAIL basic_pix%0d: got (%0d,%0d) %h fd=%b want (%0d,0) %h fd=0",
                         i, pix_q[i].x, pix_q[i].y, pix_q[i].d, pix_q[i].fd, i, exp_d[i]);
            end
            if (i + 1 < rise_q.size()) begin
                vectors++;
                if (pix_q[i].c - rise_q[i+1] !== 3) begin
                    miscompares++;
                    $display("FAIL basic_latency%0d: got %0d want 3", i,
                             pix_q[i].c - rise_q[i+1]);
                end
            end
        end
        vectors++;
        if (cmd_cnt !== 1 || cmd_code !== 8'h2C || err_cnt !== 0) begin
            miscompares++;
            $display("FAIL basic_cmd: got cnt=%0d code=%h err=%0d want 1 2c 0",
                     cmd_cnt, cmd_code, err_cnt);
        end
    endtask

    task automatic test_window_wrap();
        logic [7:0] prm [8] = '{8'h00, 8'h02, 8'h00, 8'h04, 8'h00, 8'h01, 8'h00, 8'h02};
        int ex_x [9] = '{2, 3, 4, 2, 3, 4, 2, 3, 4};
        int ex_y [9] = '{1, 1, 1, 2, 2, 2, 1, 1, 1};
        clear_events();
        cmd(8'h2A);
        for (int i = 0; i < 4; i++) dat({8'h00, prm[i]});
        cmd(8'h2B);
        for (int i = 4; i < 8; i++) dat({8'h00, prm[i]});
        cmd(8'h2C);
        for (int i = 0; i < 9; i++) dat(16'hA000 + 16'(i));
        idle(4);
        vectors++;
        if (par_i_q.size() !== 8) begin
            miscompares++;
            $display("FAIL win_param_count: got %0d want 8", par_i_q.size());
        end
        for (int i = 0; i < 8 && i < par_i_q.size(); i++) begin
            vectors++;
            if (par_i_q[i] !== 4'(i % 4) || par_d_q[i] !== prm[i]) begin
                miscompares++;
                $display("FAIL win_param%0d: got idx=%0d d=%h want idx=%0d d=%h",
                         i, par_i_q[i], par_d_q[i], i % 4, prm[i]);
            end
        end
        vectors++;
        if (pix_q.size() !== 9 || frame_cnt !== 1) begin
            miscompares++;
            $display("FAIL win_pix_count: got pix=%0d frames=%0d want 9 1",
                     pix_q.size(), frame_cnt);
        end
        for (int i = 0; i < 9 && i < pix_q.size(); i++) begin
            vectors++;
            if (pix_q[i].x !== 10'(ex_x[i]) || pix_q[i].y !== 10'(ex_y[i])
                || pix_q[i].d !== 16'hA000 + 16'(i) || pix_q[i].fd !== (i == 5)) begin
                miscompares++;
                $display("FAIL win_pix%0d: got (%0d,%0d) %h fd=%b want (%0d,%0d) fd=%b",
                         i, pix_q[i].x, pix_q[i].y, pix_q[i].d, pix_q[i].fd,
                         ex_x[i], ex_y[i], i == 5);
            end
        end
    endtask

    task automatic test_bad_window();
        clear_events();
        cmd(8'h2A);
        dat(16'h0000); dat(16'h0005); dat(16'h0000); dat(16'h0002);
        cmd(8'h2C);
        idle(2);
        vectors++;
        if (err_cnt !== 1) begin
            miscompares++;
            $display("FAIL bad_win_cmd_err: got %0d want 1", err_cnt);
        end
        dat(16'h1234);
        dat(16'h5678);
        idle(4);
        vectors++;
        if (err_cnt !== 3 || pix_q.size() !== 0) begin
            miscompares++;
            $display("FAIL bad_win_data: got err=%0d pix=%0d want 3 0", err_cnt, pix_q.size());
        end
    endtask

    task automatic test_status();
        clear_events();
        cmd(8'h11);
        cmd(8'h29);
        idle(3);
        vectors++;
        if (sleep_out !== 1'b1 || disp_on !== 1'b1) begin
            miscompares++;
            $display("FAIL status_on: got sleep=%b disp=%b want 1 1", sleep_out, disp_on);
        end
        cmd(8'h28);
        idle(3);
        vectors++;
        if (sleep_out !== 1'b1 || disp_on !== 1'b0) begin
            miscompares++;
            $display("FAIL status_disp_off: got sleep=%b disp=%b want 1 0", sleep_out, disp_on);
        end
        cmd(8'h29);
        idle(2);
        rst = 1'b0;
        idle(4);
        rst = 1'b1;
        idle(4);
        vectors++;
        if (sleep_out !== 1'b0 || disp_on !== 1'b0) begin
            miscompares++;
            $display("FAIL status_rst: got sleep=%b disp=%b want 0 0", sleep_out, disp_on);
        end
        clear_events();
        cmd(8'h2C);
        dat(16'hBEEF);
        idle(4);
        vectors++;
        if (err_cnt !== 0 || pix_q.size() !== 1) begin
            miscompares++;
            $display("FAIL status_window_default: got err=%0d pix=%0d want 0 1",
                     err_cnt, pix_q.size());
        end else if (pix_q[0].x !== 10'd0 || pix_q[0].y !== 10'd0 || pix_q[0].d !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL status_window_default: got (%0d,%0d) %h want (0,0) beef",
                     pix_q[0].x, pix_q[0].y, pix_q[0].d);
        end
    endtask

    task automatic test_suppress();
        clear_events();
        bus_write(1'b1, 16'h5555, 1'b1, 1'b1);
        bus_write(1'b1, 16'h6666, 1'b0, 1'b0);
        idle(4);
        vectors++;
        if (pix_q.size() !== 0 || err_cnt !== 0 || cmd_cnt !== 0 || par_i_q.size() !== 0) begin
            miscompares++;
            $display("FAIL suppress_pulses: got pix=%0d err=%0d cmd=%0d par=%0d want all 0",
                     pix_q.size(), err_cnt, cmd_cnt, par_i_q.size());
        end
        dat(16'h7070);
        idle(4);
        vectors++;
        if (pix_q.size() !== 1) begin
            miscompares++;
            $display("FAIL suppress_resume: got pix=%0d want 1", pix_q.size());
        end else if (pix_q[0].x !== 10'd1 || pix_q[0].y !== 10'd0 || pix_q[0].d !== 16'h7070) begin
            miscompares++;
            $display("FAIL suppress_resume: got (%0d,%0d) %h want (1,0) 7070",
                     pix_q[0].x, pix_q[0].y, pix_q[0].d);
        end
    endtask

    task automatic test_back_to_back_reset();
        logic [76:0] outs;
        clear_events();
        cmd(8'h2C);
        for (int i = 0; i < 20; i++) dat(16'hC000 + 16'(i));
        idle(4);
        vectors++;
        if (pix_q.size() !== 20) begin
            miscompares++;
            $display("FAIL b2b_pix_count: got %0d want 20", pix_q.size());
        end
        for (int i = 0; i < 20 && i < pix_q.size(); i++) begin
            vectors++;
            if (pix_q[i].x !== 10'(i) || pix_q[i].y !== 10'd0 || pix_q[i].d !== 16'hC000 + 16'(i)) begin
                miscompares++;
                $display("FAIL b2b_pix%0d: got (%0d,%0d) %h want (%0d,0)",
                         i, pix_q[i].x, pix_q[i].y, pix_q[i].d, i);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        outs = {cmd_valid, cmd_code, param_valid, param_idx, param_data, pix_valid,
                pix_data, pix_x, pix_y, frame_done, sleep_out, disp_on, err};
        vectors++;
        if (outs !== 77'd0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got %h want 0", outs);
        end
        reset = 1'b1;
        clear_events();
        dat(16'h7777);
        idle(4);
        vectors++;
        if (err_cnt !== 1 || pix_q.size() !== 0) begin
            miscompares++;
            $display("FAIL midreset_idle_err: got err=%0d pix=%0d want 1 0", err_cnt, pix_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_memwr_basic();
        test_window_wrap();
        test_bad_window();
        test_status();
        test_suppress();
        test_back_to_back_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
